// File: rtl/simon_pkg.sv
// Shared definitions for the Simon sequence player: FSM states, colour codes and
// the colour-to-LED encoding used by both playback and button checking.
package simon_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      LATCH,
      SHOW_ON,
      SHOW_OFF,
      WAIT_PRESS,
      WAIT_RELEASE,
      WIN,
      LOSE
   } state_t;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      GREEN  = 2'd1,
      BLUE   = 2'd2,
      YELLOW = 2'd3
   } colour_t;

   localparam int LED_W   = 4;
   localparam int ROUND_W = 3;

   function automatic logic [LED_W-1:0] colour_to_onehot(input colour_t colour);
      return LED_W'(1) << colour;
   endfunction

   function automatic int max_of3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/simon_tick_timer.sv
// Phase timer shared by the show, gap and press-timeout phases: loaded with N-1
// on phase entry, it reports expiry on the cycle it reads zero.
module simon_tick_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   // NOTE: non-blocking assignments for clocked state so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   // Independent of load, otherwise expiry -> next state -> load would form a loop.
   assign expired = (count == '0);

endmodule

// File: rtl/simon_sequence_player.sv
// Plays Simon rounds from a generator word: shows a growing colour sequence on
// the LEDs, judges the player's presses and reports win or lose.
module simon_sequence_player
   import simon_pkg::*;
#(
   parameter int STEPS         = 4,
   parameter int SHOW_TICKS    = 25_000_000,
   parameter int GAP_TICKS     = 12_500_000,
   parameter int TIMEOUT_TICKS = 250_000_000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2*STEPS-1:0]   bit_gen_sequence,
   output logic                 seq_enable,
   input  logic [LED_W-1:0]     buttons,
   output logic [LED_W-1:0]     leds,
   output logic [ROUND_W-1:0]   round,
   output logic                 win,
   output logic                 lose
);

   localparam int IDX_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int TIMER_W = $clog2(max_of3(SHOW_TICKS, GAP_TICKS, TIMEOUT_TICKS) + 1);

   state_t               state, state_nxt;
   logic                 start_q, start_edge;
   logic [2*STEPS-1:0]   seq_reg, seq_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [ROUND_W-1:0]   round_nxt;
   logic                 idx_last, press_ok;
   logic [LED_W-1:0]     leds_nxt;
   logic                 win_nxt, lose_nxt, seq_enable_nxt;
   logic                 timer_load, timer_expired;
   logic [TIMER_W-1:0]   timer_value;

   assign start_edge = start & ~start_q;
   assign idx_last   = (ROUND_W'(idx) + ROUND_W'(1)) == round;
   assign press_ok   = buttons == colour_to_onehot(colour_t'(seq_reg[{idx, 1'b0} +: 2]));

   simon_tick_timer #(
      .WIDTH(TIMER_W)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .load    (timer_load),
      .value   (timer_value),
      .expired (timer_expired)
   );

   // Outputs are registered from the next-state decode, so they line up with state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         start_q    <= 1'b0;
         seq_reg    <= '0;
         idx        <= '0;
         round      <= '0;
         leds       <= '0;
         win        <= 1'b0;
         lose       <= 1'b0;
         seq_enable <= 1'b0;
      end else begin
         state      <= state_nxt;
         start_q    <= start;
         seq_reg    <= seq_nxt;
         idx        <= idx_nxt;
         round      <= round_nxt;
         leds       <= leds_nxt;
         win        <= win_nxt;
         lose       <= lose_nxt;
         seq_enable <= seq_enable_nxt;
      end
   end

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_nxt = state;
      seq_nxt   = seq_reg;
      idx_nxt   = idx;
      round_nxt = round;
      case (state)
         IDLE: ;
         LOAD: state_nxt = LATCH;
         LATCH: begin
            seq_nxt   = bit_gen_sequence;
            round_nxt = ROUND_W'(1);
            idx_nxt   = '0;
            state_nxt = SHOW_ON;
         end
         SHOW_ON: begin
            if (timer_expired) state_nxt = SHOW_OFF;
         end
         SHOW_OFF: begin
            if (timer_expired) begin
               if (idx_last) begin
                  idx_nxt   = '0;
                  state_nxt = WAIT_PRESS;
               end else begin
                  idx_nxt   = idx + IDX_W'(1);
                  state_nxt = SHOW_ON;
               end
            end
         end
         WAIT_PRESS: begin
            if (press_ok)                state_nxt = WAIT_RELEASE;
            else if (buttons != '0)      state_nxt = LOSE;
            else if (timer_expired)      state_nxt = LOSE;
         end
         WAIT_RELEASE: begin
            if (buttons == '0) begin
               if (!idx_last) begin
                  idx_nxt   = idx + IDX_W'(1);
                  state_nxt = WAIT_PRESS;
               end else if (round == ROUND_W'(STEPS)) begin
                  state_nxt = WIN;
               end else begin
                  round_nxt = round + ROUND_W'(1);
                  idx_nxt   = '0;
                  state_nxt = SHOW_ON;
               end
            end
         end
         WIN, LOSE: ;
         default: state_nxt = IDLE;
      endcase
      // A start edge aborts whatever is in progress.
      if (start_edge) begin
         state_nxt = LOAD;
         round_nxt = '0;
         idx_nxt   = '0;
      end
   end

   always_comb begin
      leds_nxt       = '0;
      win_nxt        = 1'b0;
      lose_nxt       = 1'b0;
      seq_enable_nxt = 1'b0;
      timer_load     = (state_nxt != state);
      timer_value    = '0;
      case (state_nxt)
         LOAD: seq_enable_nxt = 1'b1;
         SHOW_ON: begin
            leds_nxt    = colour_to_onehot(colour_t'(seq_nxt[{idx_nxt, 1'b0} +: 2]));
            timer_value = TIMER_W'(SHOW_TICKS - 1);
         end
         SHOW_OFF:     timer_value = TIMER_W'(GAP_TICKS - 1);
         WAIT_PRESS:   timer_value = TIMER_W'(TIMEOUT_TICKS - 1);
         WAIT_RELEASE: leds_nxt    = buttons;
         WIN: begin
            win_nxt  = 1'b1;
            leds_nxt = '1;
         end
         LOSE: lose_nxt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_simon_sequence_player.sv
// Self-checking bench for simon_sequence_player: scenario tasks plus randomized
// games, checked against a round/press model of the game rules.
module tb_simon_sequence_player;

   localparam int SHOW    = 4;
   localparam int GAP     = 2;
   localparam int TIMEOUT = 20;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] bit_gen_sequence;
   logic       seq_enable;
   logic [3:0] buttons;
   logic [3:0] leds;
   logic [2:0] round;
   logic       win;
   logic       lose;

   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0] exp_col [4];

   simon_sequence_player #(
      .STEPS         (4),
      .SHOW_TICKS    (SHOW),
      .GAP_TICKS     (GAP),
      .TIMEOUT_TICKS (TIMEOUT)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .bit_gen_sequence (bit_gen_sequence),
      .seq_enable       (seq_enable),
      .buttons          (buttons),
      .leds             (leds),
      .round            (round),
      .win              (win),
      .lose             (lose)
   );

   always #5 clock = ~clock;

   function automatic logic [3:0] onehot(input logic [1:0] c);
      return 4'b0001 << c;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle(input string tag);
      n_checks++;
      if (leds !== 4'b0 || round !== 3'd0 || win !== 1'b0 || lose !== 1'b0 || seq_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: leds=%b round=%0d win=%b lose=%b seq_enable=%b, want all zero",
                  tag, leds, round, win, lose, seq_enable);
      end
   endtask

   // Start edge, then act as the generator: new word appears after the enable edge.
   task automatic start_game(input logic [7:0] seq);
      bit_gen_sequence = ~seq;
      start = 1'b1;
      tick();
      n_checks++;
      if (seq_enable !== 1'b1 || leds !== 4'b0 || win !== 1'b0 || lose !== 1'b0) begin
         n_fail++;
         $display("FAIL load: seq_enable=%b leds=%b win=%b lose=%b, want 1 0000 0 0",
                  seq_enable, leds, win, lose);
      end
      start = 1'b0;
      tick();
      bit_gen_sequence = seq;
      n_checks++;
      if (seq_enable !== 1'b0 || leds !== 4'b0) begin
         n_fail++;
         $display("FAIL latch: seq_enable=%b leds=%b, want 0 0000", seq_enable, leds);
      end
      for (int k = 0; k < 4; k++) exp_col[k] = seq[2*k +: 2];
   endtask

   task automatic play_round(input int r);
      logic [3:0] want;
      for (int k = 0; k < r; k++) begin
         for (int t = 0; t < SHOW + GAP; t++) begin
            want = (t < SHOW) ? onehot(exp_col[k]) : 4'b0000;
            tick();
            n_checks++;
            if (leds !== want || round !== 3'(r) || seq_enable !== 1'b0 || win !== 1'b0 || lose !== 1'b0) begin
               n_fail++;
               $display("FAIL show r%0d k%0d t%0d: leds=%b round=%0d seq_enable=%b win=%b lose=%b, want leds=%b round=%0d",
                        r, k, t, leds, round, seq_enable, win, lose, want, r);
            end
         end
      end
   endtask

   // fail_kind: 0 wrong colour, 1 two buttons, 2 no press until timeout.
   task automatic press_round(input int r, input int fail_press, input int fail_kind, output bit lost);
      logic [3:0] want, push;
      int d, h;
      lost = 1'b0;
      for (int k = 0; k < r; k++) begin
         tick();
         n_checks++;
         if (leds !== 4'b0 || round !== 3'(r) || win !== 1'b0 || lose !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_entry r%0d k%0d: leds=%b round=%0d win=%b lose=%b, want 0000 %0d 0 0",
                     r, k, leds, round, win, lose, r);
         end
         want = onehot(exp_col[k]);
         if (k == fail_press) begin
            if (fail_kind == 2) begin
               for (int t = 1; t < TIMEOUT; t++) begin
                  tick();
                  n_checks++;
                  if (lose !== 1'b0) begin
                     n_fail++;
                     $display("FAIL timeout_early cycle %0d: lose=%b, want 0", t + 1, lose);
                  end
               end
            end else begin
               push = onehot(exp_col[k] + 2'd1);
               if (fail_kind == 1) push = push | want;
               buttons = push;
            end
            tick();
            buttons = 4'b0;
            n_checks++;
            if (lose !== 1'b1 || win !== 1'b0 || leds !== 4'b0 || round !== 3'(r)) begin
               n_fail++;
               $display("FAIL lose_entry r%0d k%0d kind%0d: lose=%b win=%b leds=%b round=%0d, want 1 0 0000 %0d",
                        r, k, fail_kind, lose, win, leds, round, r);
            end
            tick();
            n_checks++;
            if (lose !== 1'b1 || leds !== 4'b0 || round !== 3'(r)) begin
               n_fail++;
               $display("FAIL lose_hold: lose=%b leds=%b round=%0d, want 1 0000 %0d", lose, leds, round, r);
            end
            lost = 1'b1;
            return;
         end
         d = $urandom_range(0, 3);
         repeat (d) begin
            tick();
            n_checks++;
            if (leds !== 4'b0 || lose !== 1'b0) begin
               n_fail++;
               $display("FAIL waiting r%0d k%0d: leds=%b lose=%b, want 0000 0", r, k, leds, lose);
            end
         end
         buttons = want;
         tick();
         n_checks++;
         if (leds !== want || lose !== 1'b0 || round !== 3'(r)) begin
            n_fail++;
            $display("FAIL press_echo r%0d k%0d: leds=%b lose=%b round=%0d, want %b 0 %0d",
                     r, k, leds, lose, round, want, r);
         end
         h = $urandom_range(0, 2);
         repeat (h) begin
            push = want | 4'($urandom_range(0, 15));
            buttons = push;
            tick();
            n_checks++;
            if (leds !== push || lose !== 1'b0) begin
               n_fail++;
               $display("FAIL hold_echo r%0d k%0d: leds=%b lose=%b, want %b 0", r, k, leds, lose, push);
            end
         end
         buttons = 4'b0;
      end
   endtask

   task automatic run_game(input logic [7:0] seq, input int fail_round, input int fail_press, input int fail_kind);
      bit lost;
      start_game(seq);
      for (int r = 1; r <= 4; r++) begin
         play_round(r);
         press_round(r, (r == fail_round) ? fail_press : -1, fail_kind, lost);
         if (lost) return;
      end
      tick();
      n_checks++;
      if (win !== 1'b1 || lose !== 1'b0 || leds !== 4'hF || round !== 3'd4) begin
         n_fail++;
         $display("FAIL win_entry seq=%b: win=%b lose=%b leds=%b round=%0d, want 1 0 1111 4",
                  seq, win, lose, leds, round);
      end
      repeat (2) tick();
      n_checks++;
      if (win !== 1'b1 || leds !== 4'hF || round !== 3'd4) begin
         n_fail++;
         $display("FAIL win_hold: win=%b leds=%b round=%0d, want 1 1111 4", win, leds, round);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      buttons = 4'b0;
      bit_gen_sequence = 8'h5A;
      repeat (2) tick();
      check_idle("reset_state");
      reset = 1'b0;
      repeat (3) tick();
      check_idle("idle_after_reset");
   endtask

   task automatic test_full_win();
      run_game(8'b11_10_01_00, 0, -1, 0);
   endtask

   task automatic test_wrong_colour();
      run_game(8'b11_10_01_00, 2, 1, 0);
   endtask

   task automatic test_timeout();
      run_game(8'($urandom), 1, 0, 2);
   endtask

   task automatic test_multi_press_restart();
      run_game(8'b11_10_01_00, 1, 0, 1);
      run_game(8'($urandom), 0, -1, 0);
   endtask

   task automatic test_reset_mid_show();
      start_game(8'b00_01_10_11);
      repeat (2) tick();
      reset = 1'b1;
      #1;
      check_idle("async_reset");
      tick();
      reset = 1'b0;
      tick();
      check_idle("idle_after_mid_reset");
      run_game(8'($urandom), 0, -1, 0);
   endtask

   task automatic test_back_to_back();
      int fr, fp;
      start_game(8'($urandom));
      repeat (3) tick();
      run_game(8'($urandom), 0, -1, 0);
      for (int g = 0; g < 10; g++) begin
         fr = $urandom_range(0, 4);
         fp = (fr > 0) ? $urandom_range(0, fr - 1) : -1;
         run_game(8'($urandom), fr, fp, $urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_full_win();
      test_wrong_colour();
      test_timeout();
      test_multi_press_restart();
      test_reset_mid_show();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
